// File: rtl/moore_pattern_gen.sv
// -----------------------------------------------------------------------------
// moore_pattern_gen
//
// Purpose:
//    Plays a SEQ_LEN-bit pattern register out serially, MSB first, one bit per
//    clock. A run is either finite (repeat_i+1 back-to-back plays followed by a
//    one-cycle done pulse) or endless (loop_mode=1) until stop is asserted.
//    The pattern register can be reloaded while idle. Every output is a
//    register, so no input reaches an output combinationally.
//
// Ports:
//    clk        in   clock, all state changes on the rising edge
//    rst        in   asynchronous active-high reset
//    start      in   begin a run (honoured only in IDLE, stop must be low)
//    stop       in   abort a run in progress (no done pulse)
//    loop_mode  in   1 = repeat forever, 0 = finite run; latched at start
//    repeat_i   in   REP_W-bit extra play count; latched at start. The name
//                    carries a suffix because 'repeat' is a reserved word.
//    load_en    in   pattern write strobe, accepted only in IDLE
//    load_data  in   SEQ_LEN-bit new pattern value
//    output_bit out  serial pattern bit (0 outside RUN)
//    busy       out  high while in RUN
//    done       out  one-cycle completion pulse of a finite run
//    bit_idx    out  index of the bit currently shown (0 outside RUN)
// -----------------------------------------------------------------------------
module moore_pattern_gen #(
   parameter int                 SEQ_LEN      = 8,
   parameter logic [SEQ_LEN-1:0] INIT_PATTERN = 8'hB2,
   parameter int                 REP_W        = 4,
   localparam int                IDX_W        = $clog2(SEQ_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               loop_mode,
   input  logic [REP_W-1:0]   repeat_i,
   input  logic               load_en,
   input  logic [SEQ_LEN-1:0] load_data,
   output logic               output_bit,
   output logic               busy,
   output logic               done,
   output logic [IDX_W-1:0]   bit_idx
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

   // Control state
   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [REP_W-1:0]     reps_q, reps_d;
   logic                 loop_q, loop_d;
   logic [SEQ_LEN-1:0]   pattern_q, pattern_d;

   // Registered outputs
   logic                 output_bit_q, output_bit_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;

   // Bit-reversed view of the next pattern so that idx 0 selects the MSB.
   logic [SEQ_LEN-1:0]   pattern_rev_d;

   genvar gi;
   generate
      for (gi = 0; gi < SEQ_LEN; gi++) begin : g_rev
         assign pattern_rev_d[gi] = pattern_d[SEQ_LEN-1-gi];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      reps_d    = reps_q;
      loop_d    = loop_q;
      pattern_d = pattern_q;

      case (state_q)
         ST_IDLE: begin
            idx_d = '0;
            // The pattern write lands at the same edge as a start, so a
            // simultaneous load+start plays the freshly loaded pattern.
            if (load_en) begin
               pattern_d = load_data;
            end
            // stop wins over a simultaneous start.
            if (start && !stop) begin
               state_d = ST_RUN;
               idx_d   = '0;
               loop_d  = loop_mode;
               reps_d  = repeat_i;
            end
         end

         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else if (idx_q != LAST_IDX) begin
               idx_d = idx_q + IDX_W'(1);
            end else if (loop_q) begin
               idx_d = '0;
            end else if (reps_q != '0) begin
               idx_d  = '0;
               reps_d = reps_q - REP_W'(1);
            end else begin
               state_d = ST_DONE;
               idx_d   = '0;
            end
         end

         ST_DONE: begin
            // Single-cycle state: start, stop and load_en are all ignored.
            state_d = ST_IDLE;
            idx_d   = '0;
         end

         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output decode from the next state, registered alongside it so the
   // outputs line up with the state they describe.
   // ------------------------------------------------------------------------
   always_comb begin
      busy_d       = 1'b0;
      done_d       = 1'b0;
      bit_idx_d    = '0;
      output_bit_d = 1'b0;
      case (state_d)
         ST_RUN: begin
            busy_d       = 1'b1;
            bit_idx_d    = idx_d;
            output_bit_d = pattern_rev_d[idx_d];
         end
         ST_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         reps_q       <= '0;
         loop_q       <= 1'b0;
         pattern_q    <= INIT_PATTERN;
         output_bit_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         bit_idx_q    <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         reps_q       <= reps_d;
         loop_q       <= loop_d;
         pattern_q    <= pattern_d;
         output_bit_q <= output_bit_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         bit_idx_q    <= bit_idx_d;
      end
   end

   assign output_bit = output_bit_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign bit_idx    = bit_idx_q;

endmodule

// File: tb/tb_moore_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_moore_pattern_gen
//
// Directed bench for moore_pattern_gen (SEQ_LEN=8, INIT_PATTERN=8'hB2).
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// acts on the rising edge in between. Each cycle compares the packed vector
// {output_bit, busy, done, bit_idx} against a hand-computed value.
// -----------------------------------------------------------------------------
module tb_moore_pattern_gen;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       loop_mode;
   logic [3:0] rep;
   logic       load_en;
   logic [7:0] load_data;
   logic       output_bit;
   logic       busy;
   logic       done;
   logic [2:0] bit_idx;

   int checks;
   int failures;

   moore_pattern_gen #(
      .SEQ_LEN      (8),
      .INIT_PATTERN (8'hB2),
      .REP_W        (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .loop_mode  (loop_mode),
      .repeat_i   (rep),
      .load_en    (load_en),
      .load_data  (load_data),
      .output_bit (output_bit),
      .busy       (busy),
      .done       (done),
      .bit_idx    (bit_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse start for one rising edge; returns at the falling edge where the
   // first pattern bit is visible.
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({output_bit, busy, done, bit_idx} !== 6'b0) begin
         failures++;
         $display("FAIL reset_hold: got out=%b busy=%b done=%b idx=%0d, want all zero",
                  output_bit, busy, done, bit_idx);
      end
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      checks++;
      if ({output_bit, busy, done, bit_idx} !== 6'b0) begin
         failures++;
         $display("FAIL reset_idle: got out=%b busy=%b done=%b idx=%0d, want all zero",
                  output_bit, busy, done, bit_idx);
      end
      $display("test_reset complete");
   endtask

   // ------------------------------------------------------------------------
   task automatic test_single_play();
      logic [7:0] pat;
      pat = 8'b1011_0010;
      rep = 4'd0;
      loop_mode = 1'b0;
      pulse_start();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ({output_bit, busy, done, bit_idx} !== {pat[7-k], 1'b1, 1'b0, 3'(k)}) begin
            failures++;
            $display("FAIL single_play k=%0d: got out=%b busy=%b done=%b idx=%0d, want out=%b busy=1 done=0 idx=%0d",
                     k, output_bit, busy, done, bit_idx, pat[7-k], k);
         end
         @(negedge clk);
      end
      checks++;
      if ({output_bit, busy, done, bit_idx} !== 6'b001_000) begin
         failures++;
         $display("FAIL single_done: got out=%b busy=%b done=%b idx=%0d, want out=0 busy=0 done=1 idx=0",
                  output_bit, busy, done, bit_idx);
      end
      @(negedge clk);
      checks++;
      if ({output_bit, busy, done, bit_idx} !== 6'b0) begin
         failures++;
         $display("FAIL single_idle: got out=%b busy=%b done=%b idx=%0d, want all zero",
                  output_bit, busy, done, bit_idx);
      end
      $display("test_single_play complete: pattern=%h", pat);
   endtask

   // ------------------------------------------------------------------------
   task automatic test_repeat();
      logic [7:0] pat;
      int         done_seen;
      pat = 8'hB2;
      done_seen = 0;
      rep = 4'd2;
      loop_mode = 1'b0;
      pulse_start();
      rep = 4'd0;
      for (int k = 0; k < 24; k++) begin
         if (done) done_seen++;
         checks++;
         if ({output_bit, busy, done, bit_idx} !== {pat[7-(k%8)], 1'b1, 1'b0, 3'(k%8)}) begin
            failures++;
            $display("FAIL repeat k=%0d: got out=%b busy=%b done=%b idx=%0d, want out=%b busy=1 done=0 idx=%0d",
                     k, output_bit, busy, done, bit_idx, pat[7-(k%8)], k%8);
         end
         @(negedge clk);
      end
      checks++;
      if ({output_bit, busy, done, bit_idx} !== 6'b001_000) begin
         failures++;
         $display("FAIL repeat_done: got out=%b busy=%b done=%b idx=%0d, want done=1 only",
                  output_bit, busy, done, bit_idx);
      end
      @(negedge clk);
      checks++;
      if ({output_bit, busy, done, bit_idx} !== 6'b0 || done_seen != 0) begin
         failures++;
         $display("FAIL repeat_idle: got out=%b busy=%b done=%b idx=%0d early_done=%0d, want all zero and 0",
                  output_bit, busy, done, bit_idx, done_seen);
      end
      $display("test_repeat complete: plays=3");
   endtask

   // ------------------------------------------------------------------------
   task automatic test_loop_stop();
      logic [7:0] pat;
      pat = 8'hB2;
      loop_mode = 1'b1;
      rep = 4'd0;
      pulse_start();
      loop_mode = 1'b0;   // latched at start; changing it now must not matter
      for (int k = 0; k < 20; k++) begin
         checks++;
         if ({output_bit, busy, done, bit_idx} !== {pat[7-(k%8)], 1'b1, 1'b0, 3'(k%8)}) begin
            failures++;
            $display("FAIL loop k=%0d: got out=%b busy=%b done=%b idx=%0d, want out=%b busy=1 done=0 idx=%0d",
                     k, output_bit, busy, done, bit_idx, pat[7-(k%8)], k%8);
         end
         @(negedge clk);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checks++;
      if ({output_bit, busy, done, bit_idx} !== 6'b0) begin
         failures++;
         $display("FAIL stop_idle: got out=%b busy=%b done=%b idx=%0d, want all zero",
                  output_bit, busy, done, bit_idx);
      end
      @(negedge clk);
      checks++;
      if ({output_bit, busy, done, bit_idx} !== 6'b0) begin
         failures++;
         $display("FAIL stop_no_done: got out=%b busy=%b done=%b idx=%0d, want all zero",
                  output_bit, busy, done, bit_idx);
      end
      $display("test_loop_stop complete: stopped after 20 cycles");
   endtask

   // ------------------------------------------------------------------------
   task automatic test_load();
      logic [7:0] pat;
      pat = 8'hF0;
      load_en = 1'b1;
      load_data = 8'hF0;
      @(negedge clk);
      load_en = 1'b0;
      checks++;
      if ({output_bit, busy, done, bit_idx} !== 6'b0) begin
         failures++;
         $display("FAIL load_idle: got out=%b busy=%b done=%b idx=%0d, want all zero",
                  output_bit, busy, done, bit_idx);
      end
      rep = 4'd0;
      loop_mode = 1'b0;
      for (int play = 0; play < 2; play++) begin
         pulse_start();
         for (int k = 0; k < 8; k++) begin
            checks++;
            if ({output_bit, busy, done, bit_idx} !== {pat[7-k], 1'b1, 1'b0, 3'(k)}) begin
               failures++;
               $display("FAIL load_play p=%0d k=%0d: got out=%b busy=%b done=%b idx=%0d, want out=%b busy=1 done=0 idx=%0d",
                        play, k, output_bit, busy, done, bit_idx, pat[7-k], k);
            end
            // Attempt a mid-run reload on the first play; it must be ignored.
            load_en = (play == 0 && k == 2);
            load_data = 8'h0F;
            @(negedge clk);
         end
         load_en = 1'b0;
         checks++;
         if ({output_bit, busy, done, bit_idx} !== 6'b001_000) begin
            failures++;
            $display("FAIL load_done p=%0d: got out=%b busy=%b done=%b idx=%0d, want done=1 only",
                     play, output_bit, busy, done, bit_idx);
         end
         @(negedge clk);
      end
      $display("test_load complete: pattern=%h", pat);
   endtask

   // ------------------------------------------------------------------------
   task automatic test_conflicts();
      logic [7:0] pat;
      // start and stop together in IDLE: stop wins
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({output_bit, busy, done, bit_idx} !== 6'b0) begin
            failures++;
            $display("FAIL start_stop k=%0d: got out=%b busy=%b done=%b idx=%0d, want all zero",
                     k, output_bit, busy, done, bit_idx);
         end
         @(negedge clk);
      end

      // retrigger at bit_idx=3 is ignored; start during DONE is not queued
      pat = 8'hF0;
      pulse_start();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ({output_bit, busy, done, bit_idx} !== {pat[7-k], 1'b1, 1'b0, 3'(k)}) begin
            failures++;
            $display("FAIL retrigger k=%0d: got out=%b busy=%b done=%b idx=%0d, want out=%b busy=1 done=0 idx=%0d",
                     k, output_bit, busy, done, bit_idx, pat[7-k], k);
         end
         start = (k == 3);
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if ({output_bit, busy, done, bit_idx} !== 6'b001_000) begin
         failures++;
         $display("FAIL retrigger_done: got out=%b busy=%b done=%b idx=%0d, want done=1 only",
                  output_bit, busy, done, bit_idx);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({output_bit, busy, done, bit_idx} !== 6'b0) begin
            failures++;
            $display("FAIL start_in_done k=%0d: got out=%b busy=%b done=%b idx=%0d, want all zero",
                     k, output_bit, busy, done, bit_idx);
         end
         @(negedge clk);
      end

      // load and start on the same edge: new pattern is played
      pat = 8'h5A;
      load_en = 1'b1;
      load_data = 8'h5A;
      pulse_start();
      load_en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ({output_bit, busy, done, bit_idx} !== {pat[7-k], 1'b1, 1'b0, 3'(k)}) begin
            failures++;
            $display("FAIL load_start k=%0d: got out=%b busy=%b done=%b idx=%0d, want out=%b busy=1 done=0 idx=%0d",
                     k, output_bit, busy, done, bit_idx, pat[7-k], k);
         end
         @(negedge clk);
      end
      checks++;
      if ({output_bit, busy, done, bit_idx} !== 6'b001_000) begin
         failures++;
         $display("FAIL load_start_done: got out=%b busy=%b done=%b idx=%0d, want done=1 only",
                  output_bit, busy, done, bit_idx);
      end
      @(negedge clk);
      $display("test_conflicts complete");
   endtask

   // ------------------------------------------------------------------------
   task automatic test_async_reset();
      logic [7:0] pat;
      pat = 8'h5A;
      pulse_start();
      for (int k = 0; k < 6; k++) begin
         checks++;
         if ({output_bit, busy, done, bit_idx} !== {pat[7-k], 1'b1, 1'b0, 3'(k)}) begin
            failures++;
            $display("FAIL pre_reset k=%0d: got out=%b busy=%b done=%b idx=%0d, want out=%b busy=1 done=0 idx=%0d",
                     k, output_bit, busy, done, bit_idx, pat[7-k], k);
         end
         if (k < 5) @(negedge clk);
      end
      // bit_idx=5 is showing; assert reset well away from any rising edge
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({output_bit, busy, done, bit_idx} !== 6'b0) begin
         failures++;
         $display("FAIL async_reset: got out=%b busy=%b done=%b idx=%0d, want all zero",
                  output_bit, busy, done, bit_idx);
      end
      #1;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if ({output_bit, busy, done, bit_idx} !== 6'b0) begin
            failures++;
            $display("FAIL post_reset k=%0d: got out=%b busy=%b done=%b idx=%0d, want all zero",
                     k, output_bit, busy, done, bit_idx);
         end
      end
      // pattern must be back to the reset value
      pat = 8'hB2;
      pulse_start();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ({output_bit, busy, done, bit_idx} !== {pat[7-k], 1'b1, 1'b0, 3'(k)}) begin
            failures++;
            $display("FAIL reset_pattern k=%0d: got out=%b busy=%b done=%b idx=%0d, want out=%b busy=1 done=0 idx=%0d",
                     k, output_bit, busy, done, bit_idx, pat[7-k], k);
         end
         @(negedge clk);
      end
      checks++;
      if ({output_bit, busy, done, bit_idx} !== 6'b001_000) begin
         failures++;
         $display("FAIL reset_pattern_done: got out=%b busy=%b done=%b idx=%0d, want done=1 only",
                  output_bit, busy, done, bit_idx);
      end
      @(negedge clk);
      $display("test_async_reset complete");
   endtask

   // ------------------------------------------------------------------------
   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      loop_mode = 1'b0;
      rep       = 4'd0;
      load_en   = 1'b0;
      load_data = 8'h00;

      test_reset();
      test_single_play();
      test_repeat();
      test_loop_stop();
      test_load();
      test_conflicts();
      test_async_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/moore_pattern_gen.md
MOORE_PATTERN_GEN -- requirements
Module: moore_pattern_gen

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 8: pattern length in bits (>=2).
REQ-002 SHALL have parameter INIT_PATTERN, default 8'hB2: pattern register reset value, SEQ_LEN bits wide.
REQ-003 SHALL have parameter REP_W, default 4: width of the repeat-count input.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: trigger; sampled only in IDLE.
REQ-007 SHALL have port stop, input, 1 bit: abort of a run in progress.
REQ-008 SHALL have port loop_mode, input, 1 bit: 1 = repeat forever, 0 = finite run; sampled at start.
REQ-009 SHALL have port repeat, input, REP_W bits: extra plays in a finite run; total plays = repeat+1; sampled at start.
REQ-010 SHALL have port load_en, input, 1 bit: write strobe for the pattern register.
REQ-011 SHALL have port load_data, input, SEQ_LEN bits: new pattern value.
REQ-012 SHALL have port output_bit, output, 1 bit: serial pattern output, MSB first.
REQ-013 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port bit_idx, output, clog2(SEQ_LEN) bits: index of the bit currently shown.

Function
REQ-016 SHALL be a Moore machine: all outputs are functions of registered state only; no input reaches an output combinationally.
REQ-017 SHALL implement states IDLE, RUN and DONE.
REQ-018 SHALL, in IDLE with start=1 and stop=0 at an edge, enter RUN with idx=0, latch loop_mode, and load reps=repeat.
REQ-019 SHALL, in RUN, drive output_bit = pattern[SEQ_LEN-1-idx], busy=1 and bit_idx=idx; the first bit appears in the cycle after the start edge.
REQ-020 SHALL, in RUN with idx<SEQ_LEN-1, increment idx by 1 per edge.
REQ-021 SHALL, at idx=SEQ_LEN-1: if latched loop=1, wrap idx to 0; else if reps>0, wrap idx to 0 and decrement reps; else go to DONE.
REQ-022 SHALL, in DONE, drive done=1, output_bit=0 and busy=0, then go to IDLE on the next edge (exactly one cycle).
REQ-023 SHALL, in IDLE, drive output_bit=0, busy=0, done=0 and bit_idx=0.
REQ-024 SHALL, with stop=1 at any edge in RUN, go to IDLE with no done pulse; stop in DONE or IDLE has no effect.
REQ-025 SHALL ignore start in RUN and in DONE (no retrigger or restart); start in DONE is not queued.
REQ-026 SHALL, with start=1 and stop=1 at the same IDLE edge, remain in IDLE (stop wins).
REQ-027 SHALL accept load_en only in IDLE: pattern <= load_data at that edge; load_en in RUN or DONE is ignored and the pattern stays unchanged.
REQ-028 SHALL, with load_en and start at the same IDLE edge, update the pattern and start the run; the run uses the new pattern.
REQ-029 SHALL mean, for repeat=0 and loop=0, exactly SEQ_LEN busy cycles followed by one done cycle.

Reset
REQ-030 SHALL, on rst=1 (asynchronous, immediate), force: state=IDLE, idx=0, reps=0, loop latch=0, pattern=INIT_PATTERN, output_bit=0, busy=0, done=0, bit_idx=0.
REQ-031 SHALL hold that state while rst=1; the first start is honoured at the first edge after rst deasserts.
REQ-032 SHALL, on rst asserted mid-RUN, abort at once with no done pulse.

Verification (SEQ_LEN=8, INIT_PATTERN=8'hB2)
REQ-033 SHALL cover: single play. Reset, then a 1-cycle start with repeat=0, loop=0 -> output_bit 1,0,1,1,0,0,1,0 over 8 cycles, busy=1 for those 8 cycles, then done=1 for 1 cycle, then IDLE.
REQ-034 SHALL cover: repeat. Start with repeat=2 -> pattern B2 played 3 times back-to-back (24 busy cycles, bit_idx wraps 7->0 twice), then a single done pulse.
REQ-035 SHALL cover: loop and stop. Start with loop=1, run 20 cycles, then stop=1 for 1 cycle -> IDLE on that edge, output_bit=0, busy=0, no done pulse.
REQ-036 SHALL cover: load. load_en with load_data=8'hF0 in IDLE, then start -> output 1,1,1,1,0,0,0,0; load_en=8'h0F mid-run -> output is unaffected.
REQ-037 SHALL cover: conflicts. start+stop in the same IDLE cycle -> stays IDLE; start pulse at bit_idx=3 -> ignored; load_en+start in the same cycle -> new pattern played.
REQ-038 SHALL cover: async reset. Assert rst between edges at bit_idx=5 -> outputs go to 0 immediately, no done pulse; pattern returns to 8'hB2.
